mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the SoC's single-port memory between the CPU instruction-fetch port and data (load/store) port.
- Grants one transaction at a time and forwards it to memory.
- Routes the completion back to the granted requester.
- Uses round-robin on conflict and aborts hung memory transactions with a watchdog.
- Sits between cpu and the memory/ROM inside soc.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 255, max cycles to wait for mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request, held with i_addr until i_ready.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_ready  out  1  one-cycle fetch completion.
- i_rdata  out  DATA_WIDTH  fetch data, valid when i_ready.
- d_req  in  1  data request, held with payload until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  DATA_WIDTH/8  store byte enables.
- d_ready  out  1  one-cycle data completion.
- d_rdata  out  DATA_WIDTH  load data, valid when d_ready.
- err  out  1  completion was a timeout abort; valid with i_ready/d_ready.
- mem_valid  out  1  transaction to memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  DATA_WIDTH/8  byte enables; all zero for fetch and load.
- mem_ready  in  1  memory completion; mem_rdata valid this cycle.
- mem_rdata  in  DATA_WIDTH  read data.

Behaviour:

States: IDLE, BUSY_I, BUSY_D.

Reset (asynchronous, immediate, also mid-transaction):
- State goes to IDLE; last_grant = I (so data wins the first conflict); watchdog = 0.
- All mem_* outputs go to 0, including mem_valid; an in-flight transaction is abandoned, with no ready pulse.
- i_ready, d_ready and err are 0; i_rdata and d_rdata are 0.

IDLE:
- Only d_req: go to BUSY_D.
- Only i_req: go to BUSY_I.
- Both: grant the port not equal to last_grant.
- On grant, register the payload into the mem_* regs, assert mem_valid, and set last_grant.
- For a fetch grant, mem_we = 0 and mem_wstrb = 0. For a load, mem_wstrb is forced to 0.

BUSY_x:
- mem_valid and payload are held stable until mem_ready.
- Cycle with mem_ready = 1:
  - x_ready = 1 (combinational from mem_ready and state).
  - x_rdata = mem_rdata; rdata is passed through for stores too, and is don't-care there.
  - err = 0.
  - Next state is IDLE and mem_valid deasserts.
- The non-granted ready is always 0.

Latency:
- req seen in IDLE at cycle N gives mem_valid at N+1.
- Earliest ready is N+1 (memory ready the same cycle).
- There is one mandatory IDLE cycle between transactions, so peak throughput is 1 transaction per 2 cycles.

Watchdog:
- Counter is cleared on grant and increments each BUSY cycle without mem_ready.
- When the counter reaches TIMEOUT (TIMEOUT > 0):
  - x_ready = 1, err = 1, x_rdata = 0.
  - mem_valid drops next edge; go to IDLE.
- mem_ready in the same cycle as the timeout wins: normal completion, err = 0.

Requester rules:
- Dropping req before ready is illegal; the arbiter completes the transaction regardless.
- req high in the cycle after ready is a new request.

Other rules:
- A port is never granted twice in a row while the other is pending.
- Address and strobes pass through unchanged; no alignment checks.

Test Plan:
1. Reset, then i_req with i_addr = 0x00000010; memory returns 0x00500293 with 1 wait cycle -> mem_valid one cycle after req, i_ready a single pulse with i_rdata = 0x00500293, d_ready = 0, err = 0.
2. Both requests asserted together right after reset (d_addr = 0x100 load, i_addr = 0x4) -> data granted first (mem_addr = 0x100, mem_wstrb = 0), then fetch (mem_addr = 0x4); exactly one IDLE cycle between the two.
3. i_req and d_req held continuously for 6 transactions, zero-wait memory -> grants alternate D, I, D, I, D, I; a ready every 2 cycles.
4. Store d_addr = 0x200, d_wdata = 0xA5A5A5A5, d_wstrb = 4'b0011 -> mem_we = 1, mem_wstrb = 4'b0011, mem_wdata = 0xA5A5A5A5 stable until mem_ready; then d_ready = 1.
5. TIMEOUT = 4, memory never answers a load -> d_ready = 1, err = 1, d_rdata = 0 in the 4th BUSY cycle; mem_valid low next cycle. A follow-up fetch completes normally.
6. reset pulsed in the middle of BUSY_I -> mem_valid = 0 immediately (before the next clk edge); no i_ready pulse. After release, the first conflict grants data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU fetch and data ports.
// One transaction in flight at a time; a watchdog aborts memory accesses that never complete.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    err,
    output logic                    mem_valid,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // The counter only ever needs to hold TIMEOUT-1 before the abort fires.
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant_d;
    logic [WD_W-1:0]   wdog;
    logic              busy;
    logic              timeout;
    logic              done;
    logic              grant_d;
    logic              grant_i;

    always_comb begin
        busy    = (state != IDLE);
        timeout = busy && (TIMEOUT > 0) && (wdog == WD_W'(TIMEOUT - 1));
        done    = busy && (mem_ready || timeout);
        // Data wins a conflict unless it was the last port served.
        grant_d = d_req && (!i_req || !last_grant_d);
        grant_i = i_req && !grant_d;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = BUSY_D;
                else if (grant_i) state_next = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            last_grant_d <= 1'b0;
            wdog         <= '0;
        end else if (state == IDLE) begin
            wdog <= '0;
            if (grant_d) begin
                mem_valid    <= 1'b1;
                mem_we       <= d_we;
                mem_addr     <= d_addr;
                mem_wdata    <= d_wdata;
                mem_wstrb    <= d_we ? d_wstrb : STRB_W'(0);
                last_grant_d <= 1'b1;
            end else if (grant_i) begin
                mem_valid    <= 1'b1;
                mem_we       <= 1'b0;
                mem_addr     <= i_addr;
                mem_wdata    <= '0;
                mem_wstrb    <= '0;
                last_grant_d <= 1'b0;
            end
        end else if (done) begin
            mem_valid <= 1'b0;
        end else begin
            wdog <= wdog + WD_W'(1);
        end
    end

    // Completion is combinational from mem_ready; an abort returns zero data with err.
    always_comb begin
        i_ready = (state == BUSY_I) && done;
        d_ready = (state == BUSY_D) && done;
        err     = done && !mem_ready;
        i_rdata = ((state == BUSY_I) && mem_ready) ? mem_rdata : '0;
        d_rdata = ((state == BUSY_D) && mem_ready) ? mem_rdata : '0;
    end

endmodule
